fp_mult_arbiter: RTL and testbench

Shares one pipelined `fp_mult` instance between two requesters. Each cycle it grants at most one operand pair, and tracks which requester owns each in-flight operation with a tag pipeline matched to the multiplier latency. It returns each result to the owning requester. It also provides a drain handshake so the surrounding controller can quiesce the multiplier before changing configuration or applying reset.

---
 rtl/fp_mult_arbiter.sv | 80 ++++++++
 tb/tb_fp_mult_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: shares one pipelined fp_mult between two requesters with tag-tracked result return and drain handshake; define FP_ARB_RR_EN for round-robin, otherwise requester 0 has fixed priority
module fp_mult_arbiter #(
  parameter int E_WIDTH = 8,
  parameter int M_WIDTH = 23,
  parameter int LAT = 4,
  localparam int W = E_WIDTH + M_WIDTH + 1,
  localparam int CW = $clog2(LAT + 2)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  input  logic [W-1:0] mul_res,
  output logic         res0_valid,
  output logic         res1_valid,
  output logic [W-1:0] res_data,
  input  logic         drain,
  output logic         drained,
  output logic         busy
);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t        state, state_nx;
  logic [LAT:0]  tag_v, tag_id;
  logic [CW-1:0] cnt, cnt_nx;
  logic          pick1, en, issue, retire;
`ifdef FP_ARB_RR_EN
  logic          last_grant;
  always_ff @(posedge clk)
    last_grant <= !reset ? 1'b1 : issue ? req1_ready : last_grant;
`endif
  always_comb begin
`ifdef FP_ARB_RR_EN
    pick1      = req1_valid & (~req0_valid | ~last_grant);
`else
    pick1      = req1_valid & ~req0_valid;
`endif
    en         = reset & (state == RUN) & ~drain;
    req0_ready = en & req0_valid & ~pick1;
    req1_ready = en & pick1;
    issue      = req0_ready | req1_ready;
    retire     = tag_v[LAT];
    cnt_nx     = cnt + CW'(issue) - CW'(retire);
    drained    = state == DONE;
    state_nx   = state == RUN ? (drain ? DRAIN : RUN) :
                 !drain ? RUN :
                 (state == DRAIN && cnt == '0) ? DONE : state;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state      <= RUN;
      tag_v      <= '0;
      tag_id     <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      res_data   <= '0;
      res0_valid <= 1'b0;
      res1_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      tag_v      <= {tag_v[LAT-1:0], issue};
      tag_id     <= {tag_id[LAT-1:0], req1_ready};
      cnt        <= cnt_nx;
      busy       <= cnt_nx != '0;
      mul_a      <= req1_ready ? req1_a : req0_ready ? req0_a : mul_a;
      mul_b      <= req1_ready ? req1_b : req0_ready ? req0_b : mul_b;
      res_data   <= retire ? mul_res : res_data;
      res0_valid <= retire & ~tag_id[LAT];
      res1_valid <= retire & tag_id[LAT];
    end
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb_fp_mult_arbiter: scoreboard bench for fp_mult_arbiter with a behavioural LAT-stage multiplier
module tb_fp_mult_arbiter;
  localparam int LAT = 4;
  localparam int W = 32;
  localparam logic [W-1:0] TA [8] = '{32'h3FC00000, 32'h40000000, 32'h40400000, 32'h3F800000,
                                      32'hC0000000, 32'h40800000, 32'h3FC00000, 32'h40200000};
  localparam logic [W-1:0] TB [8] = '{32'h40000000, 32'h40000000, 32'h3F000000, 32'h3F800000,
                                      32'h40400000, 32'h3E800000, 32'h3FC00000, 32'h40000000};
  localparam logic [W-1:0] TP [8] = '{32'h40400000, 32'h40800000, 32'h3FC00000, 32'h3F800000,
                                      32'hC0C00000, 32'h3F800000, 32'h40100000, 32'h40A00000};
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, drain = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic req0_ready, req1_ready, res0_valid, res1_valid, drained, busy;
  logic [W-1:0] mul_a, mul_b, mul_res, res_data;
  logic [W-1:0] pipe [LAT];
  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];
  int checks = 0;
  int failures = 0;
  int n_res = 0;
  int base;
  int i0, i1;
  logic g0, g1, e0, e1, last1, v0, v1, seen;

  fp_mult_arbiter #(.E_WIDTH(8), .M_WIDTH(23), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res),
    .res0_valid(res0_valid), .res1_valid(res1_valid), .res_data(res_data),
    .drain(drain), .drained(drained), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [47:0] p;
    logic [9:0] e;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127 + {9'd0, p[47]};
    return {a[31] ^ b[31], e[7:0], p[47] ? p[46:24] : p[45:23]};
  endfunction

  always @(posedge clk) begin
    pipe[0] <= fmul(mul_a, mul_b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_res = pipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (res0_valid) chk("res1_with_res0", {31'd0, res1_valid}, 32'd0);
      if (res0_valid) begin
        n_res++;
        if (q0.size() == 0) chk("res0_unexpected_pulse", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          chk("res0_data", res_data, e);
        end
      end
      if (res1_valid) begin
        n_res++;
        if (q1.size() == 0) chk("res1_unexpected_pulse", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("res1_data", res_data, e);
        end
      end
    end
  endtask

  task automatic step(input logic s0, input int j0, input logic s1, input int j1, input logic dr);
    @(negedge clk);
    req0_valid = s0;
    req0_a = TA[j0 % 8];
    req0_b = TB[j0 % 8];
    req1_valid = s1;
    req1_a = TA[j1 % 8];
    req1_b = TB[j1 % 8];
    drain = dr;
    #2;
    g0 = req0_ready;
    g1 = req1_ready;
    chk("one_ready_max", {31'd0, g0 & g1}, 32'd0);
    chk("ready_needs_valid", {31'd0, (g0 & ~s0) | (g1 & ~s1)}, 32'd0);
    if (g0) q0.push_back(TP[j0 % 8]);
    if (g1) q1.push_back(TP[j1 % 8]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_valids", {30'd0, res1_valid, res0_valid}, 32'd0);
    chk("rst_drained", {31'd0, drained}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b1;
    q0.delete();
    q1.delete();
    n_res = 0;
  endtask

  task automatic wait_empty();
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 40 && (q0.size() != 0 || q1.size() != 0); k++) @(negedge clk);
    chk("results_all_delivered", q0.size() + q1.size(), 32'd0);
  endtask

  initial begin
    fork
      monitor();
    join_none
    do_reset();
    step(1, 0, 0, 0, 0);
    chk("t1_req0_ready", {31'd0, g0}, 32'd1);
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      chk("t1_res0_pulse_timing", {31'd0, res0_valid}, {31'd0, k == LAT + 2});
    end
    wait_empty();
    do_reset();
    i0 = 0;
    i1 = 4;
    for (int i = 0; i < 8; i++) begin
      step(1, i0, 1, i1, 0);
`ifdef FP_ARB_RR_EN
      chk("t2_grant0", {31'd0, g0}, {31'd0, i % 2 == 0});
      chk("t2_grant1", {31'd0, g1}, {31'd0, i % 2 == 1});
`else
      chk("t2_grant0", {31'd0, g0}, 32'd1);
      chk("t2_grant1", {31'd0, g1}, 32'd0);
`endif
      if (g0) i0++;
      if (g1) i1++;
    end
    wait_empty();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, i, 0, 0, 0);
      chk("t3_issue_ready", {31'd0, g0}, 32'd1);
    end
    step(1, 5, 0, 0, 1);
    chk("t3_ready_drain_cycle", {31'd0, g0}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(1, 5, 0, 0, 1);
      chk("t3_ready_while_draining", {31'd0, g0}, 32'd0);
      if (drained) begin
        seen = 1'b1;
        chk("t3_results_before_drained", n_res, 32'd5);
      end
    end
    chk("t3_drained_seen", {31'd0, seen}, 32'd1);
    step(1, 5, 0, 0, 0);
    chk("t3_ready_done_exit_cycle", {31'd0, g0}, 32'd0);
    step(1, 5, 0, 0, 0);
    chk("t3_grant_after_run", {31'd0, g0}, 32'd1);
    wait_empty();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, i, 0, 0, 0);
      chk("t4_issue_ready", {31'd0, g0}, 32'd1);
    end
    @(negedge clk);
    reset = 1'b0;
    req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    q0.delete();
    q1.delete();
    base = n_res;
    repeat (10) @(negedge clk);
    chk("t4_no_pulses_after_reset", n_res, base);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_count", {29'd0, dut.cnt}, 32'd0);
    do_reset();
    i0 = 0;
    i1 = 3;
    last1 = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      step(v0, i0, v1, i1, 0);
`ifdef FP_ARB_RR_EN
      e1 = v1 & (~v0 | ~last1);
`else
      e1 = v1 & ~v0;
`endif
      e0 = v0 & ~e1;
      if (e0 | e1) last1 = e1;
      chk("rnd_grant0", {31'd0, g0}, {31'd0, e0});
      chk("rnd_grant1", {31'd0, g1}, {31'd0, e1});
      chk("rnd_count_bound", {31'd0, dut.cnt <= 3'(LAT + 1)}, 32'd1);
      if (g0) i0++;
      if (g1) i1++;
    end
    wait_empty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
